// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch sequencer: state encoding,
// registered strobe bundle and the per-state strobe decode.
package fetch_sequencer_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int WAIT_CNT_W         = 4;
    localparam int MEM_WAIT_MAX       = 15;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_WAIT = 3'd2,
        S_READ = 3'd3,
        S_INC  = 3'd4,
        S_HOLD = 3'd5,
        S_JUMP = 3'd6
    } state_t;

    typedef struct packed {
        logic pc_cs;
        logic pc_oe;
        logic pc_en;
        logic pc_cnt_en;
        logic mar_cs;
        logic mar_en;
        logic mem_cs;
        logic mem_oe;
        logic ir_cs;
        logic ir_en;
        logic fetch_valid;
        logic busy;
    } strobes_t;

    // Moore decode; pc_oe and mem_oe are never both set by construction.
    function automatic strobes_t decode_state(state_t s);
        strobes_t d;
        d      = '0;
        d.busy = (s != S_IDLE);
        case (s)
            S_ADDR: begin
                d.pc_cs  = 1'b1;
                d.pc_oe  = 1'b1;
                d.mar_cs = 1'b1;
                d.mar_en = 1'b1;
            end
            S_WAIT: d.mem_cs = 1'b1;
            S_READ: begin
                d.mem_cs = 1'b1;
                d.mem_oe = 1'b1;
                d.ir_cs  = 1'b1;
                d.ir_en  = 1'b1;
            end
            S_INC: begin
                d.pc_cs     = 1'b1;
                d.pc_cnt_en = 1'b1;
            end
            S_HOLD: d.fetch_valid = 1'b1;
            S_JUMP: begin
                d.pc_cs = 1'b1;
                d.pc_en = 1'b1;
            end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Decoder handshake plus the strobes driven into the bus-attached PC, MAR,
// memory and IR.
interface fetch_sequencer_if;

    logic       run;
    logic       halt;
    logic       jmp_req;
    logic       ir_taken;
    logic       fetch_valid;
    logic       busy;
    logic       pc_CS;
    logic       pc_OE;
    logic       pc_EN;
    logic       pc_CNT_EN;
    logic       mar_CS;
    logic       mar_EN;
    logic       mem_CS;
    logic       mem_OE;
    logic       ir_CS;
    logic       ir_EN;
    logic [2:0] state_dbg;

    modport master (
        input  run, halt, jmp_req, ir_taken,
        output fetch_valid, busy,
        output pc_CS, pc_OE, pc_EN, pc_CNT_EN,
        output mar_CS, mar_EN, mem_CS, mem_OE, ir_CS, ir_EN,
        output state_dbg
    );

    modport slave (
        output run, halt, jmp_req, ir_taken,
        input  fetch_valid, busy,
        input  pc_CS, pc_OE, pc_EN, pc_CNT_EN,
        input  mar_CS, mar_EN, mem_CS, mem_OE, ir_CS, ir_EN,
        input  state_dbg
    );

endinterface

// File: rtl/fetch_sequencer_wait_timer.sv
// Memory wait-state down counter: loaded on MAR load, counts down in WAIT and
// saturates at zero.
module fetch_wait_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: PC->MAR, optional memory wait, mem->IR, PC+1,
// then holds the IR for the decoder and services jump loads into the PC.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int MEM_WAIT   = 0
) (
    input  logic                clk,
    input  logic                reset,
    fetch_sequencer_if.master   seq
);

    if (MEM_WAIT < 0 || MEM_WAIT > MEM_WAIT_MAX) begin : g_bad_mem_wait
        $error("fetch_sequencer: MEM_WAIT must be in 0..15");
    end
    if (DATA_WIDTH < 1) begin : g_bad_data_width
        $error("fetch_sequencer: DATA_WIDTH must be positive");
    end

    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        (MEM_WAIT == 0) ? '0 : WAIT_CNT_W'(MEM_WAIT - 1);

    state_t   state;
    state_t   next_state;
    strobes_t strb;
    logic     go;
    logic     wait_load;
    logic     wait_dec;
    logic     wait_zero;

    assign go        = seq.run & ~seq.halt;
    assign wait_load = (state == S_ADDR);
    assign wait_dec  = (state == S_WAIT);

    fetch_wait_timer #(
        .CNT_W (WAIT_CNT_W)
    ) u_wait_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (wait_load),
        .load_val (WAIT_LOAD),
        .dec      (wait_dec),
        .zero     (wait_zero)
    );

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (go) next_state = S_ADDR;
            S_ADDR: next_state = (MEM_WAIT == 0) ? S_READ : S_WAIT;
            S_WAIT: if (wait_zero) next_state = S_READ;
            S_READ: next_state = S_INC;
            S_INC:  next_state = S_HOLD;
            // jump wins over a simultaneous ir_taken
            S_HOLD: begin
                if (seq.jmp_req) begin
                    next_state = S_JUMP;
                end else if (seq.ir_taken) begin
                    next_state = go ? S_ADDR : S_IDLE;
                end
            end
            S_JUMP:  next_state = go ? S_ADDR : S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Strobes are registered from next_state so they line up with state and
    // drop asynchronously on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            strb  <= '0;
        end else begin
            state <= next_state;
            strb  <= decode_state(next_state);
        end
    end

    assign seq.pc_CS       = strb.pc_cs;
    assign seq.pc_OE       = strb.pc_oe;
    assign seq.pc_EN       = strb.pc_en;
    assign seq.pc_CNT_EN   = strb.pc_cnt_en;
    assign seq.mar_CS      = strb.mar_cs;
    assign seq.mar_EN      = strb.mar_en;
    assign seq.mem_CS      = strb.mem_cs;
    assign seq.mem_OE      = strb.mem_oe;
    assign seq.ir_CS       = strb.ir_cs;
    assign seq.ir_EN       = strb.ir_en;
    assign seq.fetch_valid = strb.fetch_valid;
    assign seq.busy        = strb.busy;
    assign seq.state_dbg   = state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench: two sequencers (MEM_WAIT 0 and 3), each with its own PC,
// MAR, IR and ROM on a muxed data bus.
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

    localparam int N = 2;

    localparam logic [9:0] SB_NONE = 10'b0000000000;
    localparam logic [9:0] SB_ADDR = 10'b1100110000;
    localparam logic [9:0] SB_WAIT = 10'b0000001000;
    localparam logic [9:0] SB_READ = 10'b0000001111;
    localparam logic [9:0] SB_INC  = 10'b1001000000;
    localparam logic [9:0] SB_JUMP = 10'b1010000000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_v   [N];
    logic       run_v     [N];
    logic       halt_v    [N];
    logic       jmp_v     [N];
    logic       take_v    [N];
    logic       drv_en_v  [N];
    logic [7:0] drv_val_v [N];
    logic       preset_v  [N];
    logic [7:0] preset_pc [N];

    logic [7:0] pc_v    [N];
    logic [7:0] ir_v    [N];
    logic [9:0] strb_v  [N];
    logic [2:0] st_v    [N];
    logic       fv_v    [N];
    logic       busy_v  [N];
    logic       clash_v [N];
    logic       float_v [N];

    int errors = 0;
    int checks = 0;
    int clash_cnt = 0;
    int float_cnt = 0;

    function automatic logic [7:0] rom(input logic [7:0] a);
        return (a == 8'h00) ? 8'hBF : 8'(a * 8'd3 + 8'h11);
    endfunction

    for (genvar g = 0; g < N; g++) begin : lane
        fetch_sequencer_if sif();
        logic [7:0] pc;
        logic [7:0] mar;
        logic [7:0] ir;
        logic [7:0] bus;
        logic [1:0] drivers;

        assign sif.run      = run_v[g];
        assign sif.halt     = halt_v[g];
        assign sif.jmp_req  = jmp_v[g];
        assign sif.ir_taken = take_v[g];

        fetch_sequencer #(
            .DATA_WIDTH (8),
            .MEM_WAIT   (g * 3)
        ) dut (
            .clk   (clk),
            .reset (reset_v[g]),
            .seq   (sif)
        );

        always_comb begin
            bus = 8'h00;
            if (sif.pc_OE)          bus = pc;
            else if (sif.mem_OE)    bus = rom(mar);
            else if (drv_en_v[g])   bus = drv_val_v[g];
        end

        assign drivers    = {1'b0, sif.pc_OE} + {1'b0, sif.mem_OE} + {1'b0, drv_en_v[g]};
        assign clash_v[g] = (drivers > 2'd1);
        assign float_v[g] = ((sif.mar_CS & sif.mar_EN) | (sif.ir_CS & sif.ir_EN) |
                             (sif.pc_CS & sif.pc_EN)) & (drivers == 2'd0);

        always_ff @(posedge clk) begin
            if (preset_v[g])                     pc <= preset_pc[g];
            else if (sif.pc_CS && sif.pc_CNT_EN) pc <= pc + 8'd1;
            else if (sif.pc_CS && sif.pc_EN)     pc <= bus;
            if (sif.mar_CS && sif.mar_EN) mar <= bus;
            if (sif.ir_CS && sif.ir_EN)   ir  <= bus;
        end

        assign pc_v[g]   = pc;
        assign ir_v[g]   = ir;
        assign st_v[g]   = sif.state_dbg;
        assign fv_v[g]   = sif.fetch_valid;
        assign busy_v[g] = sif.busy;
        assign strb_v[g] = {sif.pc_CS, sif.pc_OE, sif.pc_EN, sif.pc_CNT_EN,
                            sif.mar_CS, sif.mar_EN, sif.mem_CS, sif.mem_OE,
                            sif.ir_CS, sif.ir_EN};
    end

    always @(posedge clk) begin
        if (clash_v[0] || clash_v[1]) clash_cnt <= clash_cnt + 1;
        if (float_v[0] || float_v[1]) float_cnt <= float_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
        end
    endtask

    task automatic expect_state(input int ln, input string tag,
                                input logic [2:0] st, input logic [9:0] sb);
        check({tag, "_state"}, 32'(st_v[ln]), 32'(st));
        check({tag, "_strobes"}, 32'(strb_v[ln]), 32'(sb));
    endtask

    // Cycles from the current negedge to the next one showing fetch_valid.
    task automatic next_fetch(input int ln, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fv_v[ln] && n < 40);
    endtask

    initial begin
        int n;
        int bad;
        logic [7:0] p0;
        logic [2:0] seq_st [7];
        logic [9:0] seq_sb [7];

        for (int i = 0; i < N; i++) begin
            reset_v[i] = 1'b0; run_v[i] = 1'b0; halt_v[i] = 1'b0; jmp_v[i] = 1'b0;
            take_v[i] = 1'b0; drv_en_v[i] = 1'b0; drv_val_v[i] = 8'h00;
            preset_v[i] = 1'b1;
        end
        preset_pc[0] = 8'h00;
        preset_pc[1] = 8'h05;

        @(negedge clk);
        expect_state(0, "reset", S_IDLE, SB_NONE);
        check("reset_fv", 32'(fv_v[0]), 32'd0);
        check("reset_busy", 32'(busy_v[0]), 32'd0);
        for (int i = 0; i < N; i++) preset_v[i] = 1'b0;
        reset_v[0] = 1'b1;
        @(negedge clk);
        expect_state(0, "idle_no_run", S_IDLE, SB_NONE);

        // Single fetch from PC 0 with MEM_WAIT 0, then back-to-back.
        run_v[0] = 1'b1;
        take_v[0] = 1'b1;
        @(negedge clk);
        expect_state(0, "f1_addr", S_ADDR, SB_ADDR);
        check("f1_busy", 32'(busy_v[0]), 32'd1);
        @(negedge clk);
        expect_state(0, "f1_read", S_READ, SB_READ);
        check("f1_pc_before_inc", 32'(pc_v[0]), 32'h00);
        @(negedge clk);
        expect_state(0, "f1_inc", S_INC, SB_INC);
        check("f1_ir", 32'(ir_v[0]), 32'hBF);
        @(negedge clk);
        expect_state(0, "f1_hold", S_HOLD, SB_NONE);
        check("f1_fv", 32'(fv_v[0]), 32'd1);
        check("f1_pc", 32'(pc_v[0]), 32'h01);
        next_fetch(0, n);
        check("b2b_period", 32'(n), 32'd4);
        check("b2b_ir", 32'(ir_v[0]), 32'(rom(8'h01)));

        bad = 0;
        for (int k = 0; k < 200; k++) begin
            next_fetch(0, n);
            if (n != 4 || ir_v[0] !== rom(pc_v[0] - 8'd1)) bad++;
        end
        check("b2b_200_fetches", 32'(bad), 32'd0);

        // Decoder stalls, then a jump arrives together with ir_taken.
        take_v[0] = 1'b0;
        @(negedge clk);
        expect_state(0, "stall_hold", S_HOLD, SB_NONE);
        drv_val_v[0] = 8'h67;
        drv_en_v[0]  = 1'b1;
        jmp_v[0]     = 1'b1;
        take_v[0]    = 1'b1;
        @(negedge clk);
        expect_state(0, "jump", S_JUMP, SB_JUMP);
        jmp_v[0] = 1'b0;
        @(negedge clk);
        drv_en_v[0] = 1'b0;
        expect_state(0, "jump_addr", S_ADDR, SB_ADDR);
        check("jump_pc", 32'(pc_v[0]), 32'h67);
        jmp_v[0] = 1'b1;
        @(negedge clk);
        expect_state(0, "jmp_ignored", S_READ, SB_READ);
        jmp_v[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("jump_fv", 32'(fv_v[0]), 32'd1);
        check("jump_ir", 32'(ir_v[0]), 32'(rom(8'h67)));
        check("jump_pc_inc", 32'(pc_v[0]), 32'h68);

        // Halt during READ lets the fetch finish, then parks in IDLE.
        @(negedge clk);
        take_v[0] = 1'b0;
        p0 = pc_v[0];
        expect_state(0, "halt_addr", S_ADDR, SB_ADDR);
        @(negedge clk);
        halt_v[0] = 1'b1;
        @(negedge clk);
        expect_state(0, "halt_inc", S_INC, SB_INC);
        @(negedge clk);
        expect_state(0, "halt_hold", S_HOLD, SB_NONE);
        @(negedge clk);
        expect_state(0, "halt_hold2", S_HOLD, SB_NONE);
        take_v[0] = 1'b1;
        @(negedge clk);
        expect_state(0, "halt_idle", S_IDLE, SB_NONE);
        check("halt_busy", 32'(busy_v[0]), 32'd0);
        @(negedge clk);
        @(negedge clk);
        expect_state(0, "halt_stays", S_IDLE, SB_NONE);
        check("halt_pc_once", 32'(pc_v[0]), 32'(p0 + 8'd1));
        run_v[0] = 1'b0;

        // MEM_WAIT 3: three WAIT cycles with mem_CS before READ.
        seq_st = '{S_ADDR, S_WAIT, S_WAIT, S_WAIT, S_READ, S_INC, S_HOLD};
        seq_sb = '{SB_ADDR, SB_WAIT, SB_WAIT, SB_WAIT, SB_READ, SB_INC, SB_NONE};
        reset_v[1] = 1'b1;
        @(negedge clk);
        run_v[1]  = 1'b1;
        take_v[1] = 1'b1;
        for (int s = 0; s < 7; s++) begin
            @(negedge clk);
            expect_state(1, $sformatf("w3_step%0d", s), seq_st[s], seq_sb[s]);
        end
        check("w3_ir", 32'(ir_v[1]), 32'(rom(8'h05)));
        check("w3_pc", 32'(pc_v[1]), 32'h06);
        next_fetch(1, n);
        check("w3_period", 32'(n), 32'd7);
        check("w3_ir2", 32'(ir_v[1]), 32'(rom(8'h06)));
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            next_fetch(1, n);
            if (n != 7 || ir_v[1] !== rom(pc_v[1] - 8'd1)) bad++;
        end
        check("w3_fetches", 32'(bad), 32'd0);

        // Reset in the middle of WAIT, then restart from the same PC.
        @(negedge clk);
        @(negedge clk);
        check("rstw_in_wait", 32'(st_v[1]), 32'(S_WAIT));
        p0 = pc_v[1];
        #2 reset_v[1] = 1'b0;
        #1;
        expect_state(1, "rstw_async", S_IDLE, SB_NONE);
        check("rstw_busy", 32'(busy_v[1]), 32'd0);
        @(negedge clk);
        reset_v[1] = 1'b1;
        check("rstw_pc_kept", 32'(pc_v[1]), 32'(p0));
        @(negedge clk);
        expect_state(1, "rstw_restart", S_ADDR, SB_ADDR);
        next_fetch(1, n);
        check("rstw_latency", 32'(n), 32'd6);
        check("rstw_ir", 32'(ir_v[1]), 32'(rom(p0)));
        check("rstw_pc", 32'(pc_v[1]), 32'(p0 + 8'd1));
        run_v[1] = 1'b0;

        @(negedge clk);
        check("bus_contention", 32'(clash_cnt), 32'd0);
        check("bus_undriven", 32'(float_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1);
    end

endmodule
